// File: rtl/voq_request_gen_if.sv
// Request-generator bus: cell arrivals, drop notices, round launch with the
// frozen priority matrix, and the decision return from the scheduler.
//   master: the request generator (drives drops, start, matrix, status)
//   slave : the environment (drives arrivals and decisions)
interface voq_request_gen_if #(
  parameter int unsigned N = 4,
  parameter int unsigned P = 16
);
  localparam int unsigned PW = $clog2(P);
  localparam int unsigned DW = $clog2(N);

  logic [N-1:0]      arr_valid;
  logic [N*DW-1:0]   arr_dst;
  logic [N*PW-1:0]   arr_pri;
  logic [N-1:0]      arr_drop;
  logic              sched_start;
  logic [N*N*PW-1:0] pri_req_out;
  logic              dec_valid;
  logic [N*N-1:0]    decision;
  logic              busy;
  logic              err_timeout;
  logic              err_spurious;

  modport master (
    input  arr_valid, arr_dst, arr_pri, dec_valid, decision,
    output arr_drop, sched_start, pri_req_out, busy, err_timeout, err_spurious
  );

  modport slave (
    output arr_valid, arr_dst, arr_pri, dec_valid, decision,
    input  arr_drop, sched_start, pri_req_out, busy, err_timeout, err_spurious
  );
endinterface

// File: rtl/voq_request_gen.sv
// VOQ request generator for an NxN priority crossbar scheduler.
// Tracks per-(input,output) cell counts and aging priorities, launches a
// scheduling round with a frozen priority snapshot, and dequeues the cells
// granted by the returned decision matrix.
// Ports:
//   clk   - single rising-edge clock
//   reset - synchronous, active-high
//   bus   - master side of voq_request_gen_if (arrivals/drops, round launch,
//           decision return, busy and sticky error flags)
module voq_request_gen #(
  parameter int unsigned N          = 4,
  parameter int unsigned P          = 16,
  parameter int unsigned DEPTH      = 15,
  parameter int unsigned AGE_PERIOD = 64,
  parameter int unsigned TIMEOUT    = 32
) (
  input  logic              clk,
  input  logic              reset,
  voq_request_gen_if.master bus
);
  localparam int unsigned PW = $clog2(P);
  localparam int unsigned DW = $clog2(N);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(AGE_PERIOD);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned SW = N * N * PW;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q [N][N];
  logic [CW-1:0] cnt_d [N][N];
  logic [PW-1:0] pri_q [N][N];
  logic [PW-1:0] pri_d [N][N];
  logic [SW-1:0] snap_q, snap_d;
  logic [AW-1:0] age_q;
  logic [TW-1:0] wait_q, wait_d;
  logic          start_q, start_d;
  logic [N-1:0]  drop_q, drop_d;
  logic          err_t_q, err_t_d;
  logic          err_s_q, err_s_d;
  logic          dec_take, age_tick, any_nonempty, spur_hit;

  // Scratch values for the per-VOQ update
  logic [CW-1:0] c;
  logic [PW-1:0] p;
  logic [PW-1:0] apri;
  logic          svc, hit;

  // Global flags: aging tick, any queued cell, decision bits naming empty VOQs
  always_comb begin
    age_tick     = (age_q == AW'(AGE_PERIOD - 1));
    any_nonempty = 1'b0;
    spur_hit     = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (cnt_q[i][j] != '0) any_nonempty = 1'b1;
        if (bus.decision[j*N+i] && (snap_q[(i*N+j)*PW +: PW] == '0)) spur_hit = 1'b1;
      end
    end
  end

  // Round FSM: next state, snapshot capture, wait counter, error flags
  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    wait_d   = wait_q;
    snap_d   = snap_q;
    err_t_d  = err_t_q;
    err_s_d  = err_s_q;
    dec_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_nonempty) begin
          state_d = WAIT;
          start_d = 1'b1;
          wait_d  = '0;
          for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
              snap_d[(i*N+j)*PW +: PW] = pri_q[i][j];
            end
          end
        end
      end
      WAIT: begin
        if (bus.dec_valid) begin
          dec_take = 1'b1;
          state_d  = IDLE;
          if (spur_hit) err_s_d = 1'b1;
        end else if (wait_q == TW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          err_t_d = 1'b1;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // VOQ update, applied as service, then aging, then arrival merge
  always_comb begin
    cnt_d  = cnt_q;
    pri_d  = pri_q;
    drop_d = '0;
    c      = '0;
    p      = '0;
    apri   = '0;
    svc    = 1'b0;
    hit    = 1'b0;
    for (int i = 0; i < N; i++) begin
      apri = bus.arr_pri[i*PW +: PW];
      if (apri == '0) apri = PW'(1);
      for (int j = 0; j < N; j++) begin
        c   = cnt_q[i][j];
        p   = pri_q[i][j];
        svc = dec_take && bus.decision[j*N+i] && (snap_q[(i*N+j)*PW +: PW] != '0);
        hit = bus.arr_valid[i] && (bus.arr_dst[i*DW +: DW] == DW'(j));
        if (svc) begin
          c = c - CW'(1);
          p = (c == '0) ? '0 : PW'(1);
        end else if (age_tick && (c != '0) && (p != PW'(P - 1))) begin
          p = p + PW'(1);
        end
        if (hit) begin
          if (c < CW'(DEPTH)) begin
            c = c + CW'(1);
            if (apri > p) p = apri;
          end else begin
            drop_d[i] = 1'b1;
          end
        end
        cnt_d[i][j] = c;
        pri_d[i][j] = p;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      snap_q  <= '0;
      age_q   <= '0;
      wait_q  <= '0;
      start_q <= 1'b0;
      drop_q  <= '0;
      err_t_q <= 1'b0;
      err_s_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          cnt_q[i][j] <= '0;
          pri_q[i][j] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      age_q   <= age_tick ? '0 : age_q + AW'(1);
      wait_q  <= wait_d;
      start_q <= start_d;
      drop_q  <= drop_d;
      err_t_q <= err_t_d;
      err_s_q <= err_s_d;
      cnt_q   <= cnt_d;
      pri_q   <= pri_d;
    end
  end

  assign bus.arr_drop     = drop_q;
  assign bus.sched_start  = start_q;
  assign bus.pri_req_out  = snap_q;
  assign bus.busy         = (state_q == WAIT);
  assign bus.err_timeout  = err_t_q;
  assign bus.err_spurious = err_s_q;
endmodule

// File: doc/voq_request_gen.md
# voq_request_gen

Upstream request generator for the N×N priority crossbar scheduler. It keeps one virtual output queue (VOQ) occupancy counter and one priority register for every (input, output) pair, and ages priorities over time. It launches a scheduling round by presenting a frozen priority-request matrix with a start pulse, then consumes the returned decision matrix to dequeue the granted cells.

## Interface
- N, 4, port count (inputs = outputs)
- P, 16, priority levels; PW = $clog2(P); priority 0 means "no request"
- DEPTH, 15, maximum cells per VOQ; CW = $clog2(DEPTH+1)
- AGE_PERIOD, 64, cycles between aging ticks (≥2)
- TIMEOUT, 32, maximum cycles waiting for a decision
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- arr_valid  in  N  per-input cell arrival strobe
- arr_dst  in  N*$clog2(N)  destination output; input i uses slice i
- arr_pri  in  N*PW  arrival priority; input i uses slice i
- arr_drop  out  N  one-cycle pulse: arrival on input i was dropped because its VOQ was full
- sched_start  out  1  one-cycle round-launch pulse to the scheduler
- pri_req_out  out  N*N*PW  frozen request matrix; element [in][out] at bits (in*N+out)*PW +: PW
- dec_valid  in  1  decision strobe from the scheduler
- decision  in  N*N  bit (out*N+in) set = output `out` accepted input `in`
- busy  out  1  high while a round is outstanding (state WAIT)
- err_timeout  out  1  sticky; set when a round times out
- err_spurious  out  1  sticky; set when a decision bit names a VOQ that was empty in the snapshot

## Operation
- VOQ(i,j) state: cnt (CW bits) and pri (PW bits). Invariant: cnt==0 ⇔ pri==0.
- Arrival on input i to VOQ(i,j) with apri = max(arr_pri_i, 1):
  - If cnt<DEPTH: cnt+1 and pri <= max(pri, apri).
  - If cnt==DEPTH and no service this cycle: the cell is dropped and arr_drop[i] pulses on the next cycle.
- Aging: a free-running counter pulses a tick every AGE_PERIOD cycles. On a tick, each nonempty VOQ that is not serviced that cycle increments pri, saturating at P-1.
- Service of VOQ(i,j) (decision bit set, snapshot cnt>0): cnt-1. pri becomes 0 if cnt reaches 0; otherwise pri becomes 1, and the remaining cells restart aging.
- Same-cycle events on one VOQ, applied in this order: service, then aging, then arrival-merge.
  - Arrival plus service: cnt unchanged; pri = max(1, apri).
  - An arrival to a full VOQ that is serviced the same cycle is accepted.
- FSM states: IDLE, WAIT.
  - IDLE → WAIT when any cnt≠0. On that edge, the snapshot takes the current (pre-update) pri of all VOQs, sched_start is registered high, and the wait counter clears.
  - WAIT → IDLE on dec_valid. Service is applied for every set decision bit whose snapshot pri≠0. Set bits with snapshot pri==0 are ignored and set err_spurious.
  - WAIT → IDLE when the wait counter reaches TIMEOUT without dec_valid. err_timeout is set and no service is applied.
- dec_valid is ignored outside WAIT.
- Arrivals and aging continue during WAIT. They update cnt/pri only; the snapshot does not change.

## Timing
- Reset values: all cnt and pri = 0; snapshot = 0, so pri_req_out = 0. sched_start, busy, arr_drop, err_timeout and err_spurious = 0. FSM = IDLE. Age and wait counters = 0.
- An arrival sampled at edge k is visible in cnt/pri after edge k. It can first appear in a snapshot taken at edge k+1.
- sched_start is high for exactly the first WAIT cycle. pri_req_out is valid in that cycle and stays constant until the edge that samples dec_valid or the timeout.
- busy = (state==WAIT).
- Service takes effect at the edge that samples dec_valid. The FSM spends at least one IDLE cycle before the next start, so the minimum start-to-start spacing is round latency + 2 cycles.
- Reset asserted mid-round: everything returns to reset values on that edge. A dec_valid arriving later is ignored because the FSM is in IDLE.

## Test plan
- Reset, then 3 arrivals to VOQ(0,2) with arr_pri=5 → the next edge starts a round: sched_start=1, pri_req_out[0][2]=5, all other elements 0.
- In WAIT, set dec_valid with decision bit (2*N+0) → cnt(0,2)=2 and pri=1. The next round's snapshot shows pri_req_out[0][2]=1.
- Hold 1 cell in VOQ(1,1) with no decision for 15*AGE_PERIOD cycles → pri saturates at 15, and err_timeout sets after TIMEOUT cycles.
- Fill VOQ(3,0) to 15 cells, then send a 16th arrival → arr_drop[3]=1 for one cycle and cnt stays 15. Repeat with a same-cycle service → the arrival is accepted and cnt stays 15.
- Send a decision bit for empty VOQ(2,3) → err_spurious=1 and no counter changes. Send dec_valid while in IDLE → no effect.
- Assert reset while in WAIT → pri_req_out=0, busy=0, all counters 0. A dec_valid pulse after reset changes nothing.
